// File: rtl/pll_rst_seq.sv
// pll_rst_seq: synchronises PLL lock, holds sys_rst until lock is stable, then times the SDRAM power-up wait.
// Lock loss re-asserts reset within SYNC_STAGES+1 edges; define PLL_RST_SEQ_LOSS_CNT_EN to add lock_loss_cnt.
module pll_rst_seq #(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned STABLE_CYCLES     = 1024,
  parameter int unsigned SDRAM_WAIT_CYCLES = 20000,
  parameter int unsigned CNT_W             = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked_in,
  output logic       sys_rst,
  output logic       sdram_ready,
  output logic [1:0] state_o
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STABLE     = 2'd1,
    WAIT_SDRAM = 2'd2,
    READY      = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(SDRAM_WAIT_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("pll_rst_seq: SYNC_STAGES must be at least 2");
  end
  if (STABLE_CYCLES < 1 || SDRAM_WAIT_CYCLES < 1) begin : g_chk_cycles
    $error("pll_rst_seq: STABLE_CYCLES and SDRAM_WAIT_CYCLES must be at least 1");
  end
  if (((STABLE_CYCLES - 1) >> CNT_W) != 0 || ((SDRAM_WAIT_CYCLES - 1) >> CNT_W) != 0) begin : g_chk_cnt_w
    $error("pll_rst_seq: CNT_W too narrow for the configured cycle counts");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sys_rst_q;
  logic                   sdram_ready_q;

  // Only the first stage sees the asynchronous lock flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_in};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Lock loss is tested before terminal count so it always wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (locked_s) begin
          state_d = STABLE;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = IDLE;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = WAIT_SDRAM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_SDRAM: begin
        if (!locked_s) begin
          state_d = IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        if (!locked_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode the next state so they move on the same edge as state_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sys_rst_q     <= 1'b1;
      sdram_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sys_rst_q     <= (state_d == IDLE) || (state_d == STABLE);
      sdram_ready_q <= (state_d == READY);
    end
  end

  assign sys_rst     = sys_rst_q;
  assign sdram_ready = sdram_ready_q;
  assign state_o     = state_q;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt_q;
  logic       lock_drop;

  assign lock_drop = (state_q != IDLE) && !locked_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else if (lock_drop && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: randomized and directed lock patterns checked against a run-length model.
`timescale 1ns/1ps
module tb_pll_rst_seq;
  localparam int SYNC = 2;
  localparam int S    = 8;
  localparam int W    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked_in = 1'b0;
  logic       sys_rst;
  logic       sdram_ready;
  logic [1:0] state_o;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_rst_seq #(
    .SYNC_STAGES(SYNC),
    .STABLE_CYCLES(S),
    .SDRAM_WAIT_CYCLES(W),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .locked_in(locked_in),
    .sys_rst(sys_rst),
    .sdram_ready(sdram_ready),
    .state_o(state_o)
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  // Reference: m_run counts consecutive edges at which the delayed lock was seen high.
  int          m_run  = 0;
  int          m_loss = 0;
  int unsigned m_hist[$];
  logic        m_seen;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run  = 0;
      m_loss = 0;
      m_hist.delete();
    end else begin
      m_hist.push_back(int'(locked_in));
      m_seen = (m_hist.size() > SYNC) ? (m_hist[m_hist.size()-1-SYNC] != 0) : 1'b0;
      while (m_hist.size() > SYNC + 1) void'(m_hist.pop_front());
      if (!m_seen) begin
        if (m_run > 0 && m_loss < 255) m_loss++;
        m_run = 0;
      end else if (m_run < 100000) begin
        m_run++;
      end
    end
  end

  function automatic logic [1:0] exp_st(int r);
    if (r == 0) return 2'd0;
    if (r <= S) return 2'd1;
    if (r <= S + W) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic exp_rst(int r);
    return (r <= S);
  endfunction

  function automatic logic exp_rdy(int r);
    return (r > S + W);
  endfunction

  task automatic apply_reset();
    locked_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    locked_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
    checks++;
    if (sys_rst !== 1'b1) begin errors++; $display("FAIL reset_sys_rst got %b want 1", sys_rst); end
    checks++;
    if (sdram_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", sdram_ready); end
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    checks++;
    if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL reset_loss got %0d want 0", lock_loss_cnt); end
`endif
    locked_in = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_power_up();
    int fall_k = 0;
    int rdy_k  = 0;
    int seq    = 0;
    logic [1:0] prev = 2'd0;
    apply_reset();
    locked_in = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      checks++;
      if (state_o !== exp_st(m_run) || sys_rst !== exp_rst(m_run) || sdram_ready !== exp_rdy(m_run)) begin
        errors++;
        $display("FAIL powerup_model t=%0t state=%0d/%0d sys_rst=%b/%b ready=%b/%b", $time,
                 state_o, exp_st(m_run), sys_rst, exp_rst(m_run), sdram_ready, exp_rdy(m_run));
      end
      if (fall_k == 0 && sys_rst === 1'b0) fall_k = k;
      if (rdy_k == 0 && sdram_ready === 1'b1) rdy_k = k;
      if (state_o !== prev) begin seq = seq * 4 + int'(state_o); prev = state_o; end
    end
    checks++;
    if (fall_k != SYNC + 1 + S) begin errors++; $display("FAIL powerup_rst_fall got edge %0d want %0d", fall_k, SYNC + 1 + S); end
    checks++;
    if (rdy_k != SYNC + 1 + S + W) begin errors++; $display("FAIL powerup_ready got edge %0d want %0d", rdy_k, SYNC + 1 + S + W); end
    checks++;
    if (seq != 27) begin errors++; $display("FAIL powerup_state_steps got code %0d want 27 (1,2,3)", seq); end
  endtask

  task automatic test_glitch();
    int hit = 0;
    int saw_idle = 0;
    int fall_k = 0;
    apply_reset();
    locked_in = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_run == 6) begin hit = 1; break; end
    end
    checks++;
    if (hit == 0) begin errors++; $display("FAIL glitch_reach_count5 got no hit want hit within 40 edges"); end
    checks++;
    if (state_o !== 2'd1) begin errors++; $display("FAIL glitch_in_stable got %0d want 1", state_o); end
    locked_in = 1'b0;
    @(negedge clk);
    locked_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (state_o !== exp_st(m_run) || sys_rst !== exp_rst(m_run) || sdram_ready !== exp_rdy(m_run)) begin
        errors++;
        $display("FAIL glitch_model t=%0t state=%0d/%0d sys_rst=%b/%b ready=%b/%b", $time,
                 state_o, exp_st(m_run), sys_rst, exp_rst(m_run), sdram_ready, exp_rdy(m_run));
      end
      if (state_o === 2'd0) saw_idle = 1;
      if (fall_k == 0 && sys_rst === 1'b0) fall_k = k;
    end
    checks++;
    if (saw_idle != 1) begin errors++; $display("FAIL glitch_idle got %0d want 1", saw_idle); end
    checks++;
    if (fall_k != SYNC + 1 + S) begin errors++; $display("FAIL glitch_restart got edge %0d want %0d", fall_k, SYNC + 1 + S); end
  endtask

  task automatic test_ready_loss();
    int reach = 0;
    int got = 0;
    apply_reset();
    locked_in = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (state_o === 2'd3) begin reach = 1; break; end
    end
    checks++;
    if (reach == 0) begin errors++; $display("FAIL ready_reach got state %0d want 3", state_o); end
    locked_in = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (state_o !== exp_st(m_run) || sys_rst !== exp_rst(m_run) || sdram_ready !== exp_rdy(m_run)) begin
        errors++;
        $display("FAIL ready_loss_model t=%0t state=%0d/%0d sys_rst=%b/%b ready=%b/%b", $time,
                 state_o, exp_st(m_run), sys_rst, exp_rst(m_run), sdram_ready, exp_rdy(m_run));
      end
      if (got == 0 && state_o === 2'd0 && sys_rst === 1'b1 && sdram_ready === 1'b0) got = k;
    end
    checks++;
    if (got < 1 || got > SYNC + 1) begin errors++; $display("FAIL ready_loss_latency got edge %0d want 1..%0d", got, SYNC + 1); end
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    checks++;
    if (lock_loss_cnt !== 8'(m_loss) || m_loss != 1) begin
      errors++; $display("FAIL ready_loss_cnt got %0d want 1", lock_loss_cnt);
    end
`endif
  endtask

  task automatic test_async_reset();
    int reach = 0;
    int fall_k = 0;
    int rdy_k = 0;
    apply_reset();
    locked_in = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (state_o === 2'd2) begin reach = 1; break; end
    end
    checks++;
    if (reach == 0) begin errors++; $display("FAIL areset_reach_wait got state %0d want 2", state_o); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("FAIL areset_state got %0d want 0", state_o); end
    checks++;
    if (sys_rst !== 1'b1) begin errors++; $display("FAIL areset_sys_rst got %b want 1", sys_rst); end
    checks++;
    if (sdram_ready !== 1'b0) begin errors++; $display("FAIL areset_ready got %b want 0", sdram_ready); end
    #1 rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (state_o !== exp_st(m_run) || sys_rst !== exp_rst(m_run) || sdram_ready !== exp_rdy(m_run)) begin
        errors++;
        $display("FAIL areset_model t=%0t state=%0d/%0d sys_rst=%b/%b ready=%b/%b", $time,
                 state_o, exp_st(m_run), sys_rst, exp_rst(m_run), sdram_ready, exp_rdy(m_run));
      end
      if (fall_k == 0 && sys_rst === 1'b0) fall_k = k;
      if (rdy_k == 0 && sdram_ready === 1'b1) rdy_k = k;
    end
    checks++;
    if (fall_k != SYNC + 1 + S) begin errors++; $display("FAIL areset_replay_fall got edge %0d want %0d", fall_k, SYNC + 1 + S); end
    checks++;
    if (rdy_k != SYNC + 1 + S + W) begin errors++; $display("FAIL areset_replay_ready got edge %0d want %0d", rdy_k, SYNC + 1 + S + W); end
  endtask

  task automatic test_terminal_loss();
    int saw_wait = 0;
    logic [1:0] st10 = 2'd0;
    logic [1:0] st11 = 2'd3;
    apply_reset();
    locked_in = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      checks++;
      if (state_o !== exp_st(m_run) || sys_rst !== exp_rst(m_run) || sdram_ready !== exp_rdy(m_run)) begin
        errors++;
        $display("FAIL term_loss_model t=%0t state=%0d/%0d sys_rst=%b/%b ready=%b/%b", $time,
                 state_o, exp_st(m_run), sys_rst, exp_rst(m_run), sdram_ready, exp_rdy(m_run));
      end
      if (state_o === 2'd2) saw_wait = 1;
      if (k == SYNC + S) st10 = state_o;
      if (k == SYNC + S + 1) st11 = state_o;
      if (k == S) locked_in = 1'b0;
    end
    checks++;
    if (st10 !== 2'd1) begin errors++; $display("FAIL term_loss_pre got %0d want 1", st10); end
    checks++;
    if (st11 !== 2'd0) begin errors++; $display("FAIL term_loss_next got %0d want 0", st11); end
    checks++;
    if (saw_wait != 0) begin errors++; $display("FAIL term_loss_no_wait got %0d want 0", saw_wait); end
  endtask

  task automatic test_random();
    int lvl;
    int hold;
    apply_reset();
    for (int seg = 0; seg < 80; seg++) begin
      lvl  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      hold = (lvl != 0) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 3));
      locked_in = (lvl != 0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checks++;
        if (state_o !== exp_st(m_run) || sys_rst !== exp_rst(m_run) || sdram_ready !== exp_rdy(m_run)) begin
          errors++;
          $display("FAIL random_model t=%0t state=%0d/%0d sys_rst=%b/%b ready=%b/%b", $time,
                   state_o, exp_st(m_run), sys_rst, exp_rst(m_run), sdram_ready, exp_rdy(m_run));
        end
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
        checks++;
        if (lock_loss_cnt !== 8'(m_loss)) begin
          errors++; $display("FAIL random_loss_cnt got %0d want %0d", lock_loss_cnt, m_loss);
        end
`endif
      end
    end
  endtask

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  task automatic test_saturation();
    apply_reset();
    for (int e = 1; e <= 260; e++) begin
      locked_in = 1'b1;
      repeat (3) @(negedge clk);
      locked_in = 1'b0;
      repeat (3) @(negedge clk);
      if (e == 200) begin
        checks++;
        if (lock_loss_cnt !== 8'd200) begin errors++; $display("FAIL sat_mid got %0d want 200", lock_loss_cnt); end
      end
    end
    checks++;
    if (lock_loss_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", lock_loss_cnt); end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_up();
    test_glitch();
    test_ready_loss();
    test_async_reset();
    test_terminal_loss();
    test_random();
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    test_saturation();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
